ysyx_23060187_ifu: RTL and testbench
====================================

# ysyx_23060187_ifu

Instruction fetch unit of the ysyx_23060187 NPC. It owns the architectural PC and issues one instruction-fetch request at a time to the memory port over a valid/ready handshake. It buffers the returned word and presents it, with its PC, to the decode/execute stage. It then waits for that stage to return the next PC before starting the next fetch (non-pipelined, single instruction in flight).

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  32  fetch address (= current PC).
- rsp_valid  in  1  fetch response valid.
- rsp_ready  out  1  IFU can take a response.
- rsp_data  in  32  fetched instruction word.
- rsp_err  in  1  access fault for this response.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst  out  32  instruction word.
- inst_pc  out  32  PC of `inst`.
- inst_fault  out  1  instruction carries a fetch fault (access or misaligned).
- npc_valid  in  1  next PC from execute is valid.
- npc  in  32  next PC.
- fetch_cnt  out  32  count of instructions delivered (inst_valid & inst_ready).

## Operation
- States: REQ, WAIT, OUT, EXEC.
- REQ:
  - req_valid=1, req_addr=pc.
  - req_valid & req_ready → WAIT.
  - req_addr must stay stable while req_valid=1 and req_ready=0.
- WAIT:
  - rsp_ready=1.
  - On rsp_valid: inst<=rsp_data, inst_fault<=rsp_err, inst_pc<=pc; → OUT.
- OUT:
  - inst_valid=1; inst, inst_pc and inst_fault are held stable until the handshake.
  - On inst_ready:
    - fetch_cnt+=1.
    - If npc_valid in the same cycle, apply the npc rule below directly from OUT.
    - Otherwise → EXEC.
- EXEC: wait for npc_valid, then apply the npc rule.
- npc rule:
  - pc<=npc.
  - If npc[1:0]==0 → REQ.
  - Else no memory request is issued; inst<=32'h0, inst_fault<=1, inst_pc<=npc; → OUT.
- Ignored inputs:
  - rsp_valid is ignored outside WAIT.
  - npc_valid is ignored in REQ and WAIT, and in OUT without inst_ready.
- Defaults:
  - rsp_ready=0 outside WAIT.
  - req_valid=0 outside REQ.
  - inst_valid=0 outside OUT.
- fetch_cnt is 32-bit and wraps 32'hFFFF_FFFF → 0.
- A fault does not stop fetching; the consumer decides on the trap and supplies npc.

## Timing
- Reset (rst=0 sampled at a rising edge):
  - state=REQ, pc=RESET_PC.
  - inst=0, inst_pc=RESET_PC, inst_fault=0, fetch_cnt=0.
  - While rst=0: req_valid=0, rsp_ready=0, inst_valid=0.
- First req_valid=1 appears in the first cycle after rst is sampled high.
- Reset mid-operation: any state returns to REQ with the reset values above. An outstanding memory response after reset is dropped, because rsp_ready=0 in REQ.
- Zero-wait memory (req_ready=1, rsp_valid one cycle after acceptance):
  - REQ at cycle 0, WAIT at cycle 1, inst_valid at cycle 2.
  - With inst_ready & npc_valid at cycle 2, the next req_valid is at cycle 3: 3 cycles per instruction.
- Response latency: the earliest legal rsp_valid is the cycle after the request handshake. A response in the same cycle as acceptance is not allowed.
- Arbitrary req_ready / rsp_valid stall lengths are tolerated; no timeout.
- Misaligned npc: inst_valid (fault) is asserted the cycle after npc acceptance, with no memory traffic.
- inst_pc and inst change only on entry to OUT.

## Test plan
- Reset then zero-wait memory returning 32'h00000013:
  - req_addr=32'h8000_0000 in the first cycle after reset.
  - inst_valid two cycles later with inst=32'h00000013, inst_pc=32'h8000_0000.
  - fetch_cnt=1 after the handshake.
- Backpressure: req_ready low for 5 cycles, rsp_valid delayed 4 cycles, inst_ready low for 3 cycles:
  - req_addr and inst are stable throughout.
  - Exactly one request and one delivery occur.
- npc_valid with inst_ready in the same cycle, npc=32'h8000_0100 → next req_addr=32'h8000_0100 the following cycle, with no EXEC cycle. npc delayed 6 cycles → IFU sits in EXEC, then fetches 32'h8000_0100.
- rsp_err=1 on a fetch at 32'h8000_0004 → inst_fault=1, inst_pc=32'h8000_0004. npc=32'h8000_0002 → inst_fault=1, inst=0, inst_pc=32'h8000_0002, with req_valid never asserted.
- rst pulled low while in WAIT:
  - A response arriving during or after reset is ignored.
  - After release, the fetch restarts at 32'h8000_0000 with fetch_cnt=0.
- Spurious rsp_valid in REQ, OUT or EXEC and spurious npc_valid in WAIT → no state, pc or output change.

Source files
------------

// File: rtl/ysyx_23060187_ifu.sv
// ysyx_23060187 instruction fetch unit.
// Owns the architectural PC and keeps a single instruction in flight:
// request -> response -> hand to decode -> wait for next PC -> repeat.
// A misaligned next PC never reaches memory; it is turned into a faulting
// instruction locally so the consumer can raise the trap.
`timescale 1ns/1ps
module ysyx_23060187_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_data,
    input  logic        rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        npc_valid,
    input  logic [31:0] npc,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2,
        ST_EXEC = 2'd3
    } state_t;

    // A fetch address is usable only when word aligned.
    function automatic logic is_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] inst_r;
    logic [31:0] inst_s;
    logic [31:0] inst_pc_r;
    logic [31:0] inst_pc_s;
    logic        inst_fault_r;
    logic        inst_fault_s;
    logic [31:0] fetch_cnt_r;
    logic [31:0] fetch_cnt_s;
    logic        npc_take_s;
    // Handshake flags are registered copies of "next state is X", so they
    // are glitch-free and held low while reset is asserted.
    logic        req_valid_r;
    logic        rsp_ready_r;
    logic        inst_valid_r;

    // Next-state and datapath update for the fetch sequence.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        inst_s       = inst_r;
        inst_pc_s    = inst_pc_r;
        inst_fault_s = inst_fault_r;
        fetch_cnt_s  = fetch_cnt_r;
        npc_take_s   = 1'b0;
        case (state_r)
            ST_REQ: begin
                if (req_valid_r && req_ready) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (rsp_ready_r && rsp_valid) begin
                    inst_s       = rsp_data;
                    inst_fault_s = rsp_err;
                    inst_pc_s    = pc_r;
                    state_s      = ST_OUT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (inst_valid_r && inst_ready) begin
                    fetch_cnt_s = fetch_cnt_r + 32'd1;
                    if (npc_valid) begin
                        npc_take_s = 1'b1;
                    end else begin
                        state_s = ST_EXEC;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            ST_EXEC: begin
                if (npc_valid) begin
                    npc_take_s = 1'b1;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            default: begin
                state_s = ST_REQ;
            end
        endcase
        // Next-PC acceptance is shared by OUT (same-cycle) and EXEC.
        if (npc_take_s) begin
            pc_s = npc;
            if (is_aligned(npc[1:0])) begin
                state_s = ST_REQ;
            end else begin
                inst_s       = 32'h0000_0000;
                inst_fault_s = 1'b1;
                inst_pc_s    = npc;
                state_s      = ST_OUT;
            end
        end else begin
            pc_s = pc_s;
        end
    end

    // State, datapath and handshake-flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_REQ;
            pc_r         <= RESET_PC;
            inst_r       <= 32'h0000_0000;
            inst_pc_r    <= RESET_PC;
            inst_fault_r <= 1'b0;
            fetch_cnt_r  <= 32'h0000_0000;
            req_valid_r  <= 1'b0;
            rsp_ready_r  <= 1'b0;
            inst_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            inst_r       <= inst_s;
            inst_pc_r    <= inst_pc_s;
            inst_fault_r <= inst_fault_s;
            fetch_cnt_r  <= fetch_cnt_s;
            req_valid_r  <= (state_s == ST_REQ);
            rsp_ready_r  <= (state_s == ST_WAIT);
            inst_valid_r <= (state_s == ST_OUT);
        end
    end

    assign req_valid  = req_valid_r;
    assign req_addr   = pc_r;
    assign rsp_ready  = rsp_ready_r;
    assign inst_valid = inst_valid_r;
    assign inst       = inst_r;
    assign inst_pc    = inst_pc_r;
    assign inst_fault = inst_fault_r;
    assign fetch_cnt  = fetch_cnt_r;

endmodule

// File: tb/tb_ysyx_23060187_ifu.sv
// Self-checking bench for ysyx_23060187_ifu: the bench plays memory and the
// decode/execute stage, and tracks the expected PC / delivery count itself.
`timescale 1ns/1ps
module tb_ysyx_23060187_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        npc_valid;
    logic [31:0] npc;
    logic [31:0] fetch_cnt;

    int pass_cnt;
    int check_cnt;

    // reference model state
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;

    // observations from the driver tasks
    logic [31:0] f_addr;
    logic [31:0] f_inst;
    logic [31:0] f_inst_pc;
    logic        f_fault;
    bit          f_timeout;
    bit          f_addr_stable;
    bit          f_wait_ok;
    bit          d_ok;

    ysyx_23060187_ifu #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_fault(inst_fault), .npc_valid(npc_valid), .npc(npc), .fetch_cnt(fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // memory contents: any address-dependent word, with a NOP at the reset vector
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h0000_0013;
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic bit coin(input bit en);
        if (!en) return 1'b0;
        return bit'($urandom_range(0, 1));
    endfunction

    // Drive one fetch from REQ to OUT with the given stalls; records observations.
    task automatic run_fetch(input int req_stall, input int rsp_delay, input logic err, input bit noise);
        int n;
        f_timeout = 0; f_addr_stable = 1; f_wait_ok = 1;
        n = 0;
        while (req_valid !== 1'b1 && n < 20) begin step; n++; end
        if (req_valid !== 1'b1) begin f_timeout = 1; return; end
        f_addr = req_addr;
        for (int i = 0; i < req_stall; i++) begin
            req_ready = 1'b0; rsp_valid = coin(noise); rsp_data = $urandom;
            npc_valid = coin(noise); npc = $urandom;
            step;
            if (req_valid !== 1'b1 || req_addr !== f_addr || rsp_ready !== 1'b0 || inst_valid !== 1'b0)
                f_addr_stable = 0;
        end
        req_ready = 1'b1; rsp_valid = 1'b0; npc_valid = 1'b0;
        step;
        req_ready = 1'b0;
        for (int i = 0; i < rsp_delay; i++) begin
            if (rsp_ready !== 1'b1 || req_valid !== 1'b0 || inst_valid !== 1'b0) f_wait_ok = 0;
            rsp_valid = 1'b0; npc_valid = coin(noise); npc = $urandom;
            step;
        end
        if (rsp_ready !== 1'b1 || req_valid !== 1'b0) f_wait_ok = 0;
        rsp_valid = 1'b1; rsp_data = mem_word(f_addr); rsp_err = err; npc_valid = coin(noise); npc = $urandom;
        step;
        rsp_valid = 1'b0; rsp_err = 1'b0; npc_valid = 1'b0;
        if (inst_valid !== 1'b1) f_timeout = 1;
        f_inst = inst; f_inst_pc = inst_pc; f_fault = inst_fault;
    endtask

    // Hand the instruction in OUT to decode and return npc after npc_delay cycles.
    task automatic run_deliver(input int inst_stall, input int npc_delay, input logic [31:0] npc_v, input bit noise);
        logic [31:0] i0, p0;
        logic        f0;
        d_ok = (inst_valid === 1'b1);
        i0 = inst; p0 = inst_pc; f0 = inst_fault;
        for (int i = 0; i < inst_stall; i++) begin
            inst_ready = 1'b0; npc_valid = coin(noise); npc = $urandom; rsp_valid = coin(noise);
            step;
            if (inst_valid !== 1'b1 || inst !== i0 || inst_pc !== p0 || inst_fault !== f0 ||
                req_valid !== 1'b0 || rsp_ready !== 1'b0) d_ok = 0;
        end
        inst_ready = 1'b1; rsp_valid = 1'b0; npc_valid = (npc_delay == 0); npc = npc_v;
        step;
        inst_ready = 1'b0; npc_valid = 1'b0;
        if (npc_delay > 0) begin
            for (int i = 0; i < npc_delay; i++) begin
                if (inst_valid !== 1'b0 || req_valid !== 1'b0 || rsp_ready !== 1'b0 ||
                    inst !== i0 || inst_pc !== p0) d_ok = 0;
                rsp_valid = coin(noise); inst_ready = coin(noise); npc = $urandom;
                step;
            end
            if (inst_valid !== 1'b0 || req_valid !== 1'b0) d_ok = 0;
            rsp_valid = 1'b0; inst_ready = 1'b0; npc_valid = 1'b1; npc = npc_v;
            step;
            npc_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        step; step;
        check_cnt++; if (req_valid !== 1'b0 || rsp_ready !== 1'b0 || inst_valid !== 1'b0)
            $display("FAIL reset_handshakes: got req_valid=%b rsp_ready=%b inst_valid=%b want 0/0/0", req_valid, rsp_ready, inst_valid);
        else pass_cnt++;
        check_cnt++; if (inst !== 32'h0 || inst_fault !== 1'b0)
            $display("FAIL reset_inst: got inst=%h fault=%b want 0/0", inst, inst_fault); else pass_cnt++;
        check_cnt++; if (inst_pc !== RST_PC)
            $display("FAIL reset_inst_pc: got %h want %h", inst_pc, RST_PC); else pass_cnt++;
        check_cnt++; if (fetch_cnt !== 32'h0)
            $display("FAIL reset_fetch_cnt: got %h want 0", fetch_cnt); else pass_cnt++;
        rst = 1'b1;
        step;
        check_cnt++; if (req_valid !== 1'b1 || req_addr !== RST_PC)
            $display("FAIL reset_first_req: got valid=%b addr=%h want 1/%h", req_valid, req_addr, RST_PC);
        else pass_cnt++;
        exp_pc = RST_PC; exp_cnt = 32'h0;
    endtask

    task automatic test_zero_wait;
        run_fetch(0, 0, 1'b0, 1'b0);
        check_cnt++; if (f_timeout || !f_wait_ok)
            $display("FAIL zw_latency: got timeout=%0d wait_ok=%0d want 0/1", f_timeout, f_wait_ok); else pass_cnt++;
        check_cnt++; if (f_addr !== RST_PC || f_inst !== 32'h0000_0013 || f_inst_pc !== RST_PC || f_fault !== 1'b0)
            $display("FAIL zw_inst: got addr=%h inst=%h pc=%h fault=%b want %h/00000013/%h/0", f_addr, f_inst, f_inst_pc, f_fault, RST_PC, RST_PC);
        else pass_cnt++;
        run_deliver(0, 0, 32'h8000_0004, 1'b0);
        exp_cnt++; exp_pc = 32'h8000_0004;
        check_cnt++; if (fetch_cnt !== exp_cnt)
            $display("FAIL zw_fetch_cnt: got %h want %h", fetch_cnt, exp_cnt); else pass_cnt++;
        check_cnt++; if (req_valid !== 1'b1 || req_addr !== exp_pc)
            $display("FAIL zw_next_req: got valid=%b addr=%h want 1/%h", req_valid, req_addr, exp_pc); else pass_cnt++;
    endtask

    task automatic test_fault;
        run_fetch(0, 0, 1'b1, 1'b0);
        check_cnt++; if (f_timeout || f_fault !== 1'b1 || f_inst_pc !== 32'h8000_0004 || f_inst !== mem_word(32'h8000_0004))
            $display("FAIL access_fault: got fault=%b pc=%h inst=%h want 1/80000004/%h", f_fault, f_inst_pc, f_inst, mem_word(32'h8000_0004));
        else pass_cnt++;
        run_deliver(1, 0, 32'h8000_0002, 1'b0);
        exp_cnt++; exp_pc = 32'h8000_0002;
        check_cnt++; if (inst_valid !== 1'b1 || req_valid !== 1'b0 || inst !== 32'h0 || inst_fault !== 1'b1 || inst_pc !== exp_pc)
            $display("FAIL misaligned_out: got iv=%b rv=%b inst=%h fault=%b pc=%h want 1/0/0/1/%h", inst_valid, req_valid, inst, inst_fault, inst_pc, exp_pc);
        else pass_cnt++;
        run_deliver(2, 2, 32'h8000_0100, 1'b0);
        exp_cnt++; exp_pc = 32'h8000_0100;
        check_cnt++; if (!d_ok || req_valid !== 1'b1 || req_addr !== exp_pc || fetch_cnt !== exp_cnt)
            $display("FAIL misaligned_recover: got ok=%0d rv=%b addr=%h cnt=%h want 1/1/%h/%h", d_ok, req_valid, req_addr, fetch_cnt, exp_pc, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        run_fetch(5, 4, 1'b0, 1'b0);
        check_cnt++; if (f_timeout || !f_addr_stable || !f_wait_ok || f_addr !== exp_pc)
            $display("FAIL bp_request: got timeout=%0d stable=%0d wait_ok=%0d addr=%h want 0/1/1/%h", f_timeout, f_addr_stable, f_wait_ok, f_addr, exp_pc);
        else pass_cnt++;
        check_cnt++; if (f_inst !== mem_word(exp_pc) || f_inst_pc !== exp_pc)
            $display("FAIL bp_inst: got %h@%h want %h@%h", f_inst, f_inst_pc, mem_word(exp_pc), exp_pc); else pass_cnt++;
        run_deliver(3, 0, 32'h8000_0100, 1'b0);
        exp_cnt++;
        check_cnt++; if (!d_ok || fetch_cnt !== exp_cnt)
            $display("FAIL bp_delivery: got ok=%0d cnt=%h want 1/%h", d_ok, fetch_cnt, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_npc_timing;
        // same-cycle npc: REQ directly after the delivery edge
        check_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0100)
            $display("FAIL npc_same_cycle: got rv=%b addr=%h want 1/80000100", req_valid, req_addr); else pass_cnt++;
        run_fetch(0, 0, 1'b0, 1'b0);
        run_deliver(0, 6, 32'h8000_0100, 1'b0);
        exp_cnt++;
        check_cnt++; if (!d_ok || req_valid !== 1'b1 || req_addr !== 32'h8000_0100 || fetch_cnt !== exp_cnt)
            $display("FAIL npc_delayed: got ok=%0d rv=%b addr=%h cnt=%h want 1/1/80000100/%h", d_ok, req_valid, req_addr, fetch_cnt, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_spurious;
        for (int i = 0; i < 3; i++) begin
            req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = $urandom; npc_valid = 1'b1; npc = 32'h8000_0200;
            step;
        end
        rsp_valid = 1'b0; npc_valid = 1'b0;
        check_cnt++; if (req_valid !== 1'b1 || req_addr !== exp_pc || rsp_ready !== 1'b0 || inst_valid !== 1'b0 || fetch_cnt !== exp_cnt)
            $display("FAIL spurious_req: got rv=%b addr=%h rr=%b iv=%b cnt=%h want 1/%h/0/0/%h", req_valid, req_addr, rsp_ready, inst_valid, fetch_cnt, exp_pc, exp_cnt);
        else pass_cnt++;
        run_fetch(3, 3, 1'b0, 1'b1);
        check_cnt++; if (f_timeout || !f_addr_stable || f_addr !== exp_pc || f_inst !== mem_word(exp_pc))
            $display("FAIL spurious_fetch: got timeout=%0d stable=%0d addr=%h inst=%h want 0/1/%h/%h", f_timeout, f_addr_stable, f_addr, f_inst, exp_pc, mem_word(exp_pc));
        else pass_cnt++;
        run_deliver(3, 3, 32'h8000_0300, 1'b1);
        exp_cnt++; exp_pc = 32'h8000_0300;
        check_cnt++; if (!d_ok || req_addr !== exp_pc || fetch_cnt !== exp_cnt)
            $display("FAIL spurious_deliver: got ok=%0d addr=%h cnt=%h want 1/%h/%h", d_ok, req_addr, fetch_cnt, exp_pc, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        req_ready = 1'b1;
        step;
        req_ready = 1'b0;
        rst = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF; rsp_err = 1'b1;
        step; step;
        rst = 1'b1;
        step;
        check_cnt++; if (req_valid !== 1'b1 || rsp_ready !== 1'b0 || inst_valid !== 1'b0 || req_addr !== RST_PC)
            $display("FAIL reset_mid_req: got rv=%b rr=%b iv=%b addr=%h want 1/0/0/%h", req_valid, rsp_ready, inst_valid, req_addr, RST_PC);
        else pass_cnt++;
        check_cnt++; if (fetch_cnt !== 32'h0 || inst !== 32'h0 || inst_fault !== 1'b0 || inst_pc !== RST_PC)
            $display("FAIL reset_mid_state: got cnt=%h inst=%h fault=%b pc=%h want 0/0/0/%h", fetch_cnt, inst, inst_fault, inst_pc, RST_PC);
        else pass_cnt++;
        rsp_valid = 1'b0; rsp_err = 1'b0;
        exp_pc = RST_PC; exp_cnt = 32'h0;
        run_fetch(0, 0, 1'b0, 1'b0);
        check_cnt++; if (f_timeout || f_addr !== RST_PC || f_inst !== 32'h0000_0013 || f_fault !== 1'b0)
            $display("FAIL reset_mid_refetch: got timeout=%0d addr=%h inst=%h fault=%b want 0/%h/00000013/0", f_timeout, f_addr, f_inst, f_fault, RST_PC);
        else pass_cnt++;
        run_deliver(0, 0, 32'h8000_1000, 1'b0);
        exp_cnt++; exp_pc = 32'h8000_1000;
    endtask

    task automatic test_random;
        bit          mis;
        logic        err;
        logic [31:0] r;
        mis = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!mis) begin
                err = logic'($urandom_range(0, 3) == 0);
                run_fetch($urandom_range(0, 4), $urandom_range(0, 4), err, 1'b1);
                check_cnt++; if (f_timeout || !f_addr_stable || !f_wait_ok || f_addr !== exp_pc ||
                                 f_inst !== mem_word(exp_pc) || f_inst_pc !== exp_pc || f_fault !== err)
                    $display("FAIL rand_fetch[%0d]: got to=%0d st=%0d w=%0d addr=%h inst=%h pc=%h f=%b want 0/1/1/%h/%h/%h/%b",
                             k, f_timeout, f_addr_stable, f_wait_ok, f_addr, f_inst, f_inst_pc, f_fault, exp_pc, mem_word(exp_pc), exp_pc, err);
                else pass_cnt++;
            end else begin
                check_cnt++; if (inst_valid !== 1'b1 || inst !== 32'h0 || inst_fault !== 1'b1 || inst_pc !== exp_pc || req_valid !== 1'b0)
                    $display("FAIL rand_misaligned[%0d]: got iv=%b inst=%h f=%b pc=%h rv=%b want 1/0/1/%h/0", k, inst_valid, inst, inst_fault, inst_pc, req_valid, exp_pc);
                else pass_cnt++;
            end
            r = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                if (r[1:0] == 2'b00) r[0] = 1'b1;
            end else begin
                r[1:0] = 2'b00;
            end
            run_deliver($urandom_range(0, 3), $urandom_range(0, 3), r, 1'b1);
            exp_cnt++; exp_pc = r; mis = (r[1:0] != 2'b00);
            check_cnt++; if (!d_ok || fetch_cnt !== exp_cnt || (!mis && (req_valid !== 1'b1 || req_addr !== exp_pc)))
                $display("FAIL rand_deliver[%0d]: got ok=%0d cnt=%h rv=%b addr=%h want 1/%h/%b/%h", k, d_ok, fetch_cnt, req_valid, req_addr, exp_cnt, !mis, exp_pc);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt = 0; check_cnt = 0;
        rst = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0; rsp_err = 1'b0;
        inst_ready = 1'b0; npc_valid = 1'b0; npc = 32'h0;
        exp_pc = RST_PC; exp_cnt = 32'h0;
        test_reset;
        test_zero_wait;
        test_fault;
        test_backpressure;
        test_npc_timing;
        test_spurious;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
